// File: rtl/gc_gate_scheduler_pkg.sv
// Shared types and constants for the garbled-circuit gate scheduler.
//   gate_desc_t   : one AND-class gate descriptor (truth table + label addresses)
//   sched_state_t : scheduler run state
//   LAT           : issue-to-engine-output latency (one RAM read + NR_AES rounds)
package gc_sched_pkg;

    localparam int GC_S   = 20;
    localparam int GC_K   = 128;
    localparam int GC_AW  = 10;
    localparam int GC_FD  = 16;
    localparam int NR_AES = 10;
    localparam int LAT    = NR_AES + 1;

    typedef struct packed {
        logic [3:0]       truth;
        logic [GC_AW-1:0] in0;
        logic [GC_AW-1:0] in1;
        logic [GC_AW-1:0] out;
    } gate_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // True when the gate reads the given label address on either input.
    function automatic logic reads_addr(input gate_desc_t d, input logic [GC_AW-1:0] a);
        return (d.in0 == a) || (d.in1 == a);
    endfunction

endpackage

// File: rtl/gc_gate_scheduler_if.sv
// Descriptor and garbled-row streams of the gate scheduler.
//   g_*  : gate descriptor stream (valid/ready), driven by the netlist source
//   o_*  : garbled row stream (valid/ready), consumed downstream
// master = host/netlist side, slave = scheduler side.
interface gc_gate_scheduler_if #(
    parameter int S  = 20,
    parameter int K  = 128,
    parameter int AW = 10
) ();
    logic          g_valid;
    logic          g_ready;
    logic [3:0]    g_logic;
    logic [AW-1:0] g_in0;
    logic [AW-1:0] g_in1;
    logic [AW-1:0] g_out;

    logic          o_valid;
    logic          o_ready;
    logic [S-1:0]  o_gid;
    logic [2*K-1:0] o_rows;

    modport master (
        output g_valid, g_logic, g_in0, g_in1, g_out,
        input  g_ready,
        input  o_valid, o_gid, o_rows,
        output o_ready
    );

    modport slave (
        input  g_valid, g_logic, g_in0, g_in1, g_out,
        output g_ready,
        output o_valid, o_gid, o_rows,
        input  o_ready
    );
endinterface

// File: rtl/gc_gate_scheduler_row_fifo.sv
// Synchronous FIFO holding retired garbled rows until downstream accepts them.
//   clk, rst   : clock, synchronous active-high reset
//   push, data : write strobe and word
//   pop        : read strobe (ignored when empty)
//   head       : oldest word (valid while !empty)
//   count      : occupancy, used by the scheduler's credit check
//   empty      : no words stored
// A push while full is accepted when a pop happens in the same cycle.
module gc_row_fifo #(
    parameter int W     = 296,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only words between rd_ptr and wr_ptr are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/gc_gate_scheduler.sv
// Issues AND-class gates into the pipelined garbling engine, at most one per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   start, cid_in, n_gates: begin a run of n_gates gates for circuit cid_in
//   busy, done            : run in progress / one-cycle completion pulse
//   bus (slave)           : gate descriptor stream in, garbled row stream out
//   rd_addr0/1, rd_data0/1: label RAM read ports (data one cycle after address)
//   e_cid, e_gid, e_logic : engine metadata, aligned with the RAM read data
//   e_out_lbl, e_row0/1   : engine results, LAT cycles after issue
//   wr_en, wr_addr, wr_data: label RAM write-back of each output label
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; descriptors ignored
// ST_RUN   | issuing gates (stalls on hazard or missing row credit)
// ST_DRAIN | all gates issued; waiting for tracker and row FIFO to empty
// ST_DONE  | one cycle, done asserted, then back to idle
module gc_gate_scheduler
    import gc_sched_pkg::*;
#(
    parameter int S  = GC_S,
    parameter int K  = GC_K,
    parameter int AW = GC_AW,
    parameter int FD = GC_FD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [S-1:0]  cid_in,
    input  logic [S-1:0]  n_gates,
    output logic          busy,
    output logic          done,
    gc_gate_scheduler_if.slave bus,
    output logic [AW-1:0] rd_addr0,
    output logic [AW-1:0] rd_addr1,
    input  logic [K-1:0]  rd_data0,
    input  logic [K-1:0]  rd_data1,
    output logic [S-1:0]  e_cid,
    output logic [S-1:0]  e_gid,
    output logic [3:0]    e_logic,
    input  logic [K-1:0]  e_out_lbl,
    input  logic [K-1:0]  e_row0,
    input  logic [K-1:0]  e_row1,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [K-1:0]  wr_data
);
    localparam int FCW = $clog2(FD + 1);
    localparam int CW  = $clog2(FD + LAT + 1);
    localparam int RW  = S + 2 * K;

    sched_state_t   state;
    sched_state_t   state_nx;

    logic [S-1:0]   remaining;
    logic [S-1:0]   gid_q;
    logic [S-1:0]   cid_q;

    // Tracker: slot k holds the gate issued k+1 cycles ago; slot LAT-1 retires.
    logic [LAT-1:0] slot_valid;
    logic [AW-1:0]  slot_addr [LAT];
    logic [S-1:0]   slot_gid  [LAT];

    gate_desc_t     desc;
    logic           hazard;
    logic           credit_ok;
    logic           g_ready_int;
    logic           issue;
    logic           retire;
    logic [CW-1:0]  inflight;

    logic [RW-1:0]  fifo_head;
    logic [FCW-1:0] fifo_count;
    logic           fifo_empty;
    logic           o_valid_int;

    // The RAM read data goes straight to the engine; the scheduler only aligns
    // the metadata with it, so these inputs carry no logic here.
    logic unused_rd;
    assign unused_rd = ^{rd_data0, rd_data1};

    assign desc = '{truth: bus.g_logic, in0: bus.g_in0, in1: bus.g_in1, out: bus.g_out};

    // The retiring slot counts too: its label is written at the end of this
    // cycle, and a same-cycle read would return the old label.
    always_comb begin
        hazard   = 1'b0;
        inflight = '0;
        for (int k = 0; k < LAT; k++) begin
            if (slot_valid[k] && reads_addr(desc, slot_addr[k])) hazard = 1'b1;
            inflight = inflight + CW'(slot_valid[k]);
        end
    end

    // Every in-flight gate owns a FIFO slot in advance, so the engine never
    // needs to stall and the FIFO can never overflow.
    assign credit_ok   = (CW'(fifo_count) + inflight) < CW'(FD);
    assign g_ready_int = (state == ST_RUN) && !hazard && credit_ok;
    assign issue       = bus.g_valid && g_ready_int;
    assign retire      = slot_valid[LAT-1];

    assign bus.g_ready = g_ready_int;
    assign rd_addr0    = issue ? desc.in0 : '0;
    assign rd_addr1    = issue ? desc.in1 : '0;

    assign wr_en       = retire;
    assign wr_addr     = retire ? slot_addr[LAT-1] : '0;
    assign wr_data     = retire ? e_out_lbl : '0;

    gc_row_fifo #(
        .W     (RW),
        .DEPTH (FD)
    ) u_row_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (retire),
        .data  ({slot_gid[LAT-1], e_row1, e_row0}),
        .pop   (o_valid_int && bus.o_ready),
        .head  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign o_valid_int = !fifo_empty;
    assign bus.o_valid = o_valid_int;
    assign bus.o_gid   = o_valid_int ? fifo_head[RW-1 -: S] : '0;
    assign bus.o_rows  = o_valid_int ? fifo_head[2*K-1:0] : '0;

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = (n_gates == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (issue && remaining == S'(1)) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (inflight == '0 && fifo_count == '0) state_nx = ST_DONE;
            end
            ST_DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            gid_q      <= '0;
            cid_q      <= '0;
            e_cid      <= '0;
            e_gid      <= '0;
            e_logic    <= '0;
            slot_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                slot_addr[k] <= '0;
                slot_gid[k]  <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                remaining <= n_gates;
                cid_q     <= cid_in;
                gid_q     <= '0;
            end
            if (issue) begin
                remaining <= remaining - S'(1);
                gid_q     <= gid_q + S'(1);
                e_cid     <= cid_q;
                e_gid     <= gid_q;
                e_logic   <= desc.truth;
            end
            // Bubbles shift in whenever nothing issues, keeping retire order = issue order.
            slot_valid   <= {slot_valid[LAT-2:0], issue};
            slot_addr[0] <= desc.out;
            slot_gid[0]  <= gid_q;
            for (int k = 1; k < LAT; k++) begin
                slot_addr[k] <= slot_addr[k-1];
                slot_gid[k]  <= slot_gid[k-1];
            end
        end
    end

endmodule

// File: tb/tb_gc_gate_scheduler.sv
module tb_gc_gate_scheduler;
    import gc_sched_pkg::*;

    typedef struct packed {
        logic [127:0] lbl;
        logic [127:0] r0;
        logic [127:0] r1;
    } eng_t;

    logic clk;
    logic rst;
    logic start;
    logic [19:0] cid_in, n_gates;
    logic busy, done;
    logic [9:0] rd_addr0, rd_addr1;
    logic [127:0] rd_data0, rd_data1;
    logic [19:0] e_cid, e_gid;
    logic [3:0] e_logic;
    logic [127:0] e_out_lbl, e_row0, e_row1;
    logic wr_en;
    logic [9:0] wr_addr;
    logic [127:0] wr_data;

    gc_gate_scheduler_if #(.S(GC_S), .K(GC_K), .AW(GC_AW)) bus ();

    gc_gate_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .cid_in(cid_in), .n_gates(n_gates),
        .busy(busy), .done(done), .bus(bus),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .e_cid(e_cid), .e_gid(e_gid), .e_logic(e_logic),
        .e_out_lbl(e_out_lbl), .e_row0(e_row0), .e_row1(e_row1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Garbling function of the engine model (also used by the reference model).
    function automatic eng_t eng_f(input logic [127:0] a, input logic [127:0] b,
                                   input logic [3:0] lg, input logic [19:0] gid,
                                   input logic [19:0] cid);
        eng_t r;
        r.lbl = ({a[95:0], a[127:96]} ^ b) + {cid, gid, lg, 84'h0};
        r.r0  = a ^ {b[63:0], b[127:64]} ^ {124'h0, lg};
        r.r1  = a + b + {108'h0, gid};
        return r;
    endfunction

    function automatic logic [127:0] init_lbl(input logic [9:0] a);
        return {4{22'h2B1C3, a}};
    endfunction

    // Label RAM: registered reads, read-old on same-cycle write.
    bit [127:0] mem [1024];
    bit         wrt [1024];
    always @(posedge clk) begin
        rd_data0 <= wrt[rd_addr0] ? mem[rd_addr0] : init_lbl(rd_addr0);
        rd_data1 <= wrt[rd_addr1] ? mem[rd_addr1] : init_lbl(rd_addr1);
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            wrt[wr_addr] <= 1'b1;
        end
    end

    // Engine: NR_AES pipeline stages after the RAM-aligned inputs.
    eng_t pipe [NR_AES];
    always @(posedge clk) begin
        pipe[0] <= eng_f(rd_data0, rd_data1, e_logic, e_gid, e_cid);
        for (int i = 1; i < NR_AES; i++) pipe[i] <= pipe[i-1];
    end
    assign e_out_lbl = pipe[NR_AES-1].lbl;
    assign e_row0    = pipe[NR_AES-1].r0;
    assign e_row1    = pipe[NR_AES-1].r1;

    // Observation queues, filled away from the active edge.
    logic [19:0]  got_gid [$];
    logic [255:0] got_rows [$];
    logic [9:0]   got_wa [$];
    logic [127:0] got_wd [$];
    int iss_cyc [$];
    int wr_cyc [$];
    int row_cyc [$];
    int n_iss;
    int done_cnt;

    always @(negedge clk) begin
        if (bus.g_valid && bus.g_ready) begin
            n_iss <= n_iss + 1;
            iss_cyc.push_back(cyc);
        end
        if (wr_en) begin
            got_wa.push_back(wr_addr);
            got_wd.push_back(wr_data);
            wr_cyc.push_back(cyc);
        end
        if (bus.o_valid && bus.o_ready) begin
            got_gid.push_back(bus.o_gid);
            got_rows.push_back(bus.o_rows);
            row_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // Reference: sequential netlist evaluation over a private label memory.
    bit [127:0] ref_mem [1024];
    bit         ref_wrt [1024];
    logic [19:0]  exp_gid [$];
    logic [255:0] exp_rows [$];
    logic [9:0]   exp_wa [$];
    logic [127:0] exp_wd [$];

    int n_cmp;
    int n_bad;
    int start_cyc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_gate(input logic [3:0] lg, input logic [9:0] a0, input logic [9:0] a1,
                              input logic [9:0] ao, input logic [19:0] gid, input logic [19:0] cid);
        logic [127:0] la, lb;
        eng_t r;
        la = ref_wrt[a0] ? ref_mem[a0] : init_lbl(a0);
        lb = ref_wrt[a1] ? ref_mem[a1] : init_lbl(a1);
        r = eng_f(la, lb, lg, gid, cid);
        ref_mem[ao] = r.lbl;
        ref_wrt[ao] = 1'b1;
        exp_gid.push_back(gid);
        exp_rows.push_back({r.r1, r.r0});
        exp_wa.push_back(ao);
        exp_wd.push_back(r.lbl);
    endtask

    task automatic start_run(input logic [19:0] c, input logic [19:0] n);
        start = 1'b1; cid_in = c; n_gates = n;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_gate(input logic [3:0] lg, input logic [9:0] a0, input logic [9:0] a1,
                             input logic [9:0] ao);
        bus.g_valid = 1'b1; bus.g_logic = lg; bus.g_in0 = a0; bus.g_in1 = a1; bus.g_out = ao;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.g_ready) begin
                @(posedge clk); #1;
                bus.g_valid = 1'b0;
                return;
            end
        end
        chk("issue_timeout", 256'(0), 256'(1));
        bus.g_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 256'(done), 256'(1));
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_row_count"}, 256'(got_gid.size()), 256'(exp_gid.size()));
        chk({tag, "_wr_count"}, 256'(got_wa.size()), 256'(exp_wa.size()));
        for (int i = 0; i < exp_gid.size() && i < got_gid.size(); i++) begin
            chk({tag, "_row_gid"}, 256'(got_gid[i]), 256'(exp_gid[i]));
            chk({tag, "_row_data"}, got_rows[i], exp_rows[i]);
        end
        for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
            chk({tag, "_wr_addr"}, 256'(got_wa[i]), 256'(exp_wa[i]));
            chk({tag, "_wr_data"}, 256'(got_wd[i]), 256'(exp_wd[i]));
        end
        got_gid.delete(); got_rows.delete(); got_wa.delete(); got_wd.delete();
        exp_gid.delete(); exp_rows.delete(); exp_wa.delete(); exp_wd.delete();
        iss_cyc.delete(); wr_cyc.delete(); row_cyc.delete();
    endtask

    int d0, base, w0;

    initial begin
        rst = 1'b1; start = 1'b0; cid_in = '0; n_gates = '0;
        bus.g_valid = 1'b0; bus.g_logic = '0; bus.g_in0 = '0; bus.g_in1 = '0; bus.g_out = '0;
        bus.o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_g_ready", 256'(bus.g_ready), 256'(0));
        chk("rst_o_valid", 256'(bus.o_valid), 256'(0));
        chk("rst_wr_en", 256'(wr_en), 256'(0));
        chk("rst_e_gid", 256'(e_gid), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: four independent gates, one issue per cycle, in-order rows, one done.
        d0 = done_cnt;
        start_run(20'h00011, 20'd4);
        for (int i = 0; i < 4; i++) begin
            send_gate(4'(i + 1), 10'(2 * i), 10'(2 * i + 1), 10'(50 + i));
            model_gate(4'(i + 1), 10'(2 * i), 10'(2 * i + 1), 10'(50 + i), 20'(i), 20'h00011);
        end
        chk("t1_busy", 256'(busy), 256'(1));
        wait_done();
        repeat (4) @(negedge clk);
        chk("t1_done_once", 256'(done_cnt - d0), 256'(1));
        chk("t1_issue_count", 256'(iss_cyc.size()), 256'(4));
        for (int i = 1; i < 4; i++) chk("t1_back_to_back", 256'(iss_cyc[i]), 256'(iss_cyc[0] + i));
        chk("t1_first_write", 256'(wr_cyc[0]), 256'(iss_cyc[0] + LAT));
        chk("t1_first_row", 256'(row_cyc[0]), 256'(iss_cyc[0] + LAT + 1));
        check_all("t1");

        // 2: RAW hazard on the previous output label.
        start_run(20'h00022, 20'd2);
        send_gate(4'h8, 10'd1, 10'd2, 10'd60);
        model_gate(4'h8, 10'd1, 10'd2, 10'd60, 20'd0, 20'h00022);
        send_gate(4'h7, 10'd60, 10'd3, 10'd61);
        model_gate(4'h7, 10'd60, 10'd3, 10'd61, 20'd1, 20'h00022);
        chk("t2_stall_len", 256'(iss_cyc[1]), 256'(iss_cyc[0] + LAT + 1));
        wait_done();
        check_all("t2");

        // 3: back-pressure caps in-flight + queued rows at FD.
        start_run(20'h00333, 20'd32);
        base = n_iss;
        bus.o_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 32; i++)
                    send_gate(4'(i), 10'(20 + i % 16), 10'(40 + i % 8), 10'(100 + i));
            end
            begin
                repeat (40) @(negedge clk);
                chk("t3_credit_cap", 256'(n_iss - base), 256'(GC_FD));
                chk("t3_rows_held", 256'(got_gid.size()), 256'(0));
                chk("t3_o_valid", 256'(bus.o_valid), 256'(1));
                @(posedge clk); #1;
                bus.o_ready = 1'b1;
            end
        join
        for (int i = 0; i < 32; i++)
            model_gate(4'(i), 10'(20 + i % 16), 10'(40 + i % 8), 10'(100 + i), 20'(i), 20'h00333);
        wait_done();
        check_all("t3");

        // 4: empty run finishes the cycle after start.
        start_run(20'h00044, 20'd0);
        @(negedge clk);
        chk("t4_done", 256'(done), 256'(1));
        chk("t4_done_cycle", 256'(cyc), 256'(start_cyc + 1));
        @(negedge clk);
        chk("t4_done_pulse", 256'(done), 256'(0));
        chk("t4_no_write", 256'(got_wa.size()), 256'(0));
        chk("t4_no_row", 256'(got_gid.size()), 256'(0));
        check_all("t4");

        // 5: reset with three gates in flight aborts the run.
        start_run(20'h0F0F0, 20'd8);
        for (int i = 0; i < 3; i++) send_gate(4'hF, 10'(1 + i), 10'(4 + i), 10'(200 + i));
        rst = 1'b1;
        @(negedge clk);
        chk("t5_pre_rst_gid", 256'(e_gid), 256'(2));
        w0 = got_wa.size();
        d0 = done_cnt;
        @(negedge clk);
        chk("t5_rst_busy", 256'(busy), 256'(0));
        chk("t5_rst_wr_en", 256'(wr_en), 256'(0));
        chk("t5_rst_o_valid", 256'(bus.o_valid), 256'(0));
        chk("t5_rst_g_ready", 256'(bus.g_ready), 256'(0));
        chk("t5_rst_e_gid", 256'(e_gid), 256'(0));
        chk("t5_rst_e_cid", 256'(e_cid), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        chk("t5_no_write", 256'(got_wa.size()), 256'(w0));
        chk("t5_no_done", 256'(done_cnt), 256'(d0));
        @(posedge clk); #1;
        check_all("t5a");
        start_run(20'h12345, 20'd2);
        send_gate(4'h9, 10'd60, 10'd61, 10'd210);
        @(negedge clk);
        chk("t5_restart_gid", 256'(e_gid), 256'(0));
        send_gate(4'h6, 10'd210, 10'd50, 10'd211);
        model_gate(4'h9, 10'd60, 10'd61, 10'd210, 20'd0, 20'h12345);
        model_gate(4'h6, 10'd210, 10'd50, 10'd211, 20'd1, 20'h12345);
        wait_done();
        check_all("t5");

        // 6: full-width circuit id reaches the engine unchanged.
        start_run(20'hABCDE, 20'd3);
        send_gate(4'hB, 10'd61, 10'd211, 10'd220);
        @(negedge clk);
        chk("t6_e_cid", 256'(e_cid), 256'(20'hABCDE));
        chk("t6_e_gid", 256'(e_gid), 256'(0));
        chk("t6_e_logic", 256'(e_logic), 256'(4'hB));
        send_gate(4'h1, 10'd220, 10'd5, 10'd221);
        send_gate(4'h2, 10'd7, 10'd8, 10'd222);
        model_gate(4'hB, 10'd61, 10'd211, 10'd220, 20'd0, 20'hABCDE);
        model_gate(4'h1, 10'd220, 10'd5, 10'd221, 20'd1, 20'hABCDE);
        model_gate(4'h2, 10'd7, 10'd8, 10'd222, 20'd2, 20'hABCDE);
        wait_done();
        check_all("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
